// File: rtl/ifetch_req_pkg.sv
// Shared widths, reset PC, fetch-state encoding and small helpers for the
// instruction-fetch requester.
package ifetch_req_pkg;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int INST_W  = 32;
    localparam int ENTRY_W = ADDR_W + INST_W;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [INST_W-1:0] select_inst(input logic sel_hi,
                                                      input logic [DATA_W-1:0] dw);
        return sel_hi ? dw[63:32] : dw[31:0];
    endfunction

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return pc & ~64'h0000_0000_0000_0003;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Circular {pc, inst} buffer with flush; the head is presented from registers
// and holds its last value when the buffer drains.
module ifetch_fifo
    import ifetch_req_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_head_valid,
    output logic [WIDTH-1:0]       o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd, r_wr, w_rd_next, w_wr_next;
    logic [CW-1:0]    r_count, w_count_next;
    logic             w_full, w_do_push, w_do_pop, w_mem_we;
    logic             r_head_valid, w_head_valid_next;
    logic [WIDTH-1:0] r_head, w_head_next;

    // Next pointers, occupancy and head; a push into an empty buffer shows up one cycle later.
    always_comb begin
        w_full    = (r_count == CW'(DEPTH));
        w_do_pop  = i_pop && (r_count != '0);
        w_do_push = i_push && (!w_full || w_do_pop);
        w_mem_we  = w_do_push && !i_flush;
        if (i_flush) begin
            w_rd_next    = '0;
            w_wr_next    = '0;
            w_count_next = '0;
        end else begin
            w_rd_next    = w_do_pop  ? r_rd + PW'(1) : r_rd;
            w_wr_next    = w_do_push ? r_wr + PW'(1) : r_wr;
            w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
        if (i_flush || (w_count_next == '0)) begin
            w_head_valid_next = 1'b0;
            w_head_next       = r_head;
        end else if (w_do_push && (w_rd_next == r_wr)) begin
            w_head_valid_next = 1'b1;
            w_head_next       = i_push_data;
        end else begin
            w_head_valid_next = 1'b1;
            w_head_next       = r_mem[w_rd_next];
        end
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr] <= i_push_data;
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd         <= '0;
            r_wr         <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_head       <= '0;
        end else begin
            r_rd         <= w_rd_next;
            r_wr         <= w_wr_next;
            r_count      <= w_count_next;
            r_head_valid <= w_head_valid_next;
            r_head       <= w_head_next;
        end
    end

    assign o_count      = r_count;
    assign o_head_valid = r_head_valid;
    assign o_head       = r_head;

endmodule

// File: rtl/ifetch_req.sv
// Instruction-fetch requester: one outstanding icache request at a time,
// redirect handling, and a small decode-side instruction buffer.
module ifetch_req
    import ifetch_req_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] icache_addr,
    output logic        icache_addr_valid,
    input  logic [63:0] icache_data,
    input  logic        icache_data_valid,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e       r_state;
    logic [63:0]        r_pc, r_addr;
    logic               r_addr_valid;
    logic [63:0]        w_redir_pc, w_pc_inc;
    logic               w_push, w_pop, w_head_valid, w_issue_ok;
    logic [CW-1:0]      w_count, w_count_next;
    logic [ENTRY_W-1:0] w_push_entry, w_head;

    assign w_redir_pc   = align_pc(redirect_pc);
    assign w_pc_inc     = r_pc + 64'd4;
    assign w_push       = (r_state == ST_REQ) && icache_data_valid && !redirect_valid;
    assign w_pop        = w_head_valid && inst_ready && !redirect_valid;
    assign w_push_entry = {r_pc, select_inst(r_pc[2], icache_data)};

    // Slot reservation: a new request may go out only if the buffer, as it will be
    // after this edge, still has room for its response.
    always_comb begin
        if (redirect_valid) begin
            w_count_next = '0;
        end else begin
            w_count_next = w_count + CW'(w_push) - CW'(w_pop);
        end
        w_issue_ok = (w_count_next < CW'(DEPTH));
    end

    // Fetch FSM with PC and registered request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_addr_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue_ok) begin
                        r_state      <= ST_REQ;
                        r_addr_valid <= 1'b1;
                        r_addr       <= redirect_valid ? w_redir_pc : r_pc;
                    end else begin
                        r_state      <= ST_IDLE;
                        r_addr_valid <= 1'b0;
                    end
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                end
                ST_REQ: begin
                    if (redirect_valid) begin
                        r_pc         <= w_redir_pc;
                        r_addr_valid <= 1'b0;
                        r_state      <= icache_data_valid ? ST_IDLE : ST_DROP;
                    end else if (icache_data_valid) begin
                        r_pc <= w_pc_inc;
                        if (w_issue_ok) begin
                            r_addr <= w_pc_inc;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_addr_valid <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    // The stale response still has to be absorbed before fetching again.
                    if (redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                    if (icache_data_valid) begin
                        r_state <= ST_IDLE;
                    end
                    r_addr_valid <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_addr_valid <= 1'b0;
                end
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk          (clk),
        .i_rst_n      (rst),
        .i_flush      (redirect_valid),
        .i_push       (w_push),
        .i_push_data  (w_push_entry),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_head_valid (w_head_valid),
        .o_head       (w_head)
    );

    assign icache_addr       = r_addr;
    assign icache_addr_valid = r_addr_valid;
    assign inst_valid        = w_head_valid;
    assign inst              = w_head[31:0];
    assign inst_pc           = w_head[95:32];

endmodule

// File: tb/tb_ifetch_req.sv
// Self-checking bench for ifetch_req: directed scenarios plus a randomized
// run against a queue-based model of the fetch stream.
module tb_ifetch_req;

    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 2;

    logic        clk, rst;
    logic [63:0] icache_addr;
    logic        icache_addr_valid;
    logic [63:0] icache_data;
    logic        icache_data_valid;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;

    int n_vec = 0;
    int n_bad = 0;

    ifetch_req #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .icache_addr       (icache_addr),
        .icache_addr_valid (icache_addr_valid),
        .icache_data       (icache_data),
        .icache_data_valid (icache_data_valid),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .inst_valid        (inst_valid),
        .inst              (inst),
        .inst_pc           (inst_pc),
        .inst_ready        (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: the instruction stored at byte address a is hash32(a).
    function automatic logic [31:0] hash32(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] dword_at(input logic [63:0] a);
        logic [63:0] a8;
        a8 = {a[63:3], 3'b000};
        return {hash32(a8 + 64'd4), hash32(a8)};
    endfunction

    task automatic do_reset();
        rst = 1'b0; icache_data_valid = 1'b0; icache_data = 64'd0;
        redirect_valid = 1'b0; redirect_pc = 64'd0; inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; icache_data_valid = 1'b0; icache_data = 64'd0;
        redirect_valid = 1'b0; redirect_pc = 64'd0; inst_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (icache_addr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_addr_valid got %0b want 0", icache_addr_valid); end
        n_vec++; if (icache_addr !== RPC) begin n_bad++; $display("FAIL rst_addr got %h want %h", icache_addr, RPC); end
        n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rst_inst_valid got %0b want 0", inst_valid); end
        n_vec++; if (inst !== 32'd0) begin n_bad++; $display("FAIL rst_inst got %h want 0", inst); end
        n_vec++; if (inst_pc !== 64'd0) begin n_bad++; $display("FAIL rst_inst_pc got %h want 0", inst_pc); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (icache_addr_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid got %0b want 1", icache_addr_valid); end
        n_vec++; if (icache_addr !== RPC) begin n_bad++; $display("FAIL first_req_addr got %h want %h", icache_addr, RPC); end
    endtask

    task automatic test_basic();
        do_reset();
        @(negedge clk);
        icache_data = 64'h0000_0013_00a0_0093; icache_data_valid = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid0 got %0b want 1", inst_valid); end
        n_vec++; if (inst !== 32'h00a0_0093) begin n_bad++; $display("FAIL basic_inst0 got %h want 00a00093", inst); end
        n_vec++; if (inst_pc !== RPC) begin n_bad++; $display("FAIL basic_pc0 got %h want %h", inst_pc, RPC); end
        n_vec++; if (icache_addr !== RPC + 64'd4 || icache_addr_valid !== 1'b1) begin n_bad++; $display("FAIL basic_addr1 got %h/%0b want %h/1", icache_addr, icache_addr_valid, RPC + 64'd4); end
        icache_data_valid = 1'b1; inst_ready = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0; inst_ready = 1'b0;
        n_vec++; if (inst !== 32'h0000_0013) begin n_bad++; $display("FAIL basic_inst1 got %h want 00000013", inst); end
        n_vec++; if (inst_pc !== RPC + 64'd4) begin n_bad++; $display("FAIL basic_pc1 got %h want %h", inst_pc, RPC + 64'd4); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            icache_data_valid = 1'b0;
            n_vec++; if (icache_addr_valid !== 1'b1 || icache_addr !== RPC + 64'(4 * k)) begin n_bad++; $display("FAIL bp_req%0d got %h/%0b want %h/1", k, icache_addr, icache_addr_valid, RPC + 64'(4 * k)); end
            @(negedge clk);
            icache_data = dword_at(RPC + 64'(4 * k)); icache_data_valid = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            icache_data_valid = 1'b0;
            n_vec++; if (icache_addr_valid !== 1'b0) begin n_bad++; $display("FAIL bp_stall%0d addr_valid got %0b want 0", k, icache_addr_valid); end
            n_vec++; if (inst_valid !== 1'b1 || inst_pc !== RPC) begin n_bad++; $display("FAIL bp_head%0d got %0b/%h want 1/%h", k, inst_valid, inst_pc, RPC); end
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        n_vec++; if (icache_addr_valid !== 1'b1 || icache_addr !== RPC + 64'd8) begin n_bad++; $display("FAIL bp_resume got %h/%0b want %h/1", icache_addr, icache_addr_valid, RPC + 64'd8); end
        n_vec++; if (inst_pc !== RPC + 64'd4 || inst !== hash32(RPC + 64'd4)) begin n_bad++; $display("FAIL bp_head2 got %h/%h want %h/%h", inst_pc, inst, RPC + 64'd4, hash32(RPC + 64'd4)); end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        @(negedge clk);
        icache_data = dword_at(RPC); icache_data_valid = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b1 || icache_addr_valid !== 1'b1) begin n_bad++; $display("FAIL rd_pre got %0b/%0b want 1/1", inst_valid, icache_addr_valid); end
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0103;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b0 || icache_addr_valid !== 1'b0) begin n_bad++; $display("FAIL rd_flush got %0b/%0b want 0/0", inst_valid, icache_addr_valid); end
        @(negedge clk);
        n_vec++; if (icache_addr_valid !== 1'b0) begin n_bad++; $display("FAIL rd_wait got %0b want 0", icache_addr_valid); end
        icache_data = dword_at(RPC + 64'd4); icache_data_valid = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b0 || icache_addr_valid !== 1'b0) begin n_bad++; $display("FAIL rd_discard got %0b/%0b want 0/0", inst_valid, icache_addr_valid); end
        @(negedge clk);
        n_vec++; if (icache_addr_valid !== 1'b1 || icache_addr !== 64'h0000_0000_8000_0100) begin n_bad++; $display("FAIL rd_newreq got %h/%0b want 80000100/1", icache_addr, icache_addr_valid); end
        n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL rd_noinst got %0b want 0", inst_valid); end
        icache_data = dword_at(64'h0000_0000_8000_0100); icache_data_valid = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 64'h0000_0000_8000_0100 || inst !== hash32(64'h0000_0000_8000_0100)) begin n_bad++; $display("FAIL rd_first got %0b/%h/%h want 1/80000100/%h", inst_valid, inst_pc, inst, hash32(64'h0000_0000_8000_0100)); end
    endtask

    task automatic test_redirect_same_cycle();
        do_reset();
        @(negedge clk);
        icache_data = dword_at(RPC); icache_data_valid = 1'b1;
        @(negedge clk);
        icache_data = dword_at(RPC + 64'd4); icache_data_valid = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_1234_567B; inst_ready = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        n_vec++; if (inst_valid !== 1'b0 || icache_addr_valid !== 1'b0) begin n_bad++; $display("FAIL rs_flush got %0b/%0b want 0/0", inst_valid, icache_addr_valid); end
        @(negedge clk);
        n_vec++; if (icache_addr_valid !== 1'b1 || icache_addr !== 64'h0000_0000_1234_5678) begin n_bad++; $display("FAIL rs_newreq got %h/%0b want 12345678/1", icache_addr, icache_addr_valid); end
        icache_data = dword_at(64'h0000_0000_1234_5678); icache_data_valid = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0;
        n_vec++; if (inst_pc !== 64'h0000_0000_1234_5678 || inst !== hash32(64'h0000_0000_1234_5678)) begin n_bad++; $display("FAIL rs_inst got %h/%h want 12345678/%h", inst_pc, inst, hash32(64'h0000_0000_1234_5678)); end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_vec++; if (icache_addr_valid !== 1'b1 || icache_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL wrap_req got %h/%0b want fffffffffffffffc/1", icache_addr, icache_addr_valid); end
        icache_data = dword_at(64'hFFFF_FFFF_FFFF_FFFC); icache_data_valid = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0;
        n_vec++; if (icache_addr !== 64'd0) begin n_bad++; $display("FAIL wrap_next got %h want 0", icache_addr); end
        n_vec++; if (inst !== hash32(64'hFFFF_FFFF_FFFF_FFFC)) begin n_bad++; $display("FAIL wrap_inst got %h want %h", inst, hash32(64'hFFFF_FFFF_FFFF_FFFC)); end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk);
        icache_data = dword_at(RPC); icache_data_valid = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0;
        n_vec++; if (inst_valid !== 1'b1) begin n_bad++; $display("FAIL ar_pre got %0b want 1", inst_valid); end
        #2 rst = 1'b0; icache_data_valid = 1'b1;
        #1;
        n_vec++; if (icache_addr_valid !== 1'b0 || icache_addr !== RPC) begin n_bad++; $display("FAIL ar_addr got %h/%0b want %h/0", icache_addr, icache_addr_valid, RPC); end
        n_vec++; if (inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 64'd0) begin n_bad++; $display("FAIL ar_inst got %0b/%h/%h want 0/0/0", inst_valid, inst, inst_pc); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        icache_data_valid = 1'b0;
        n_vec++; if (icache_addr_valid !== 1'b1 || icache_addr !== RPC || inst_valid !== 1'b0) begin n_bad++; $display("FAIL ar_after got %h/%0b/%0b want %h/1/0", icache_addr, icache_addr_valid, inst_valid, RPC); end
        @(negedge clk);
        n_vec++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL ar_stray got %0b want 0", inst_valid); end
    endtask

    task automatic test_random();
        logic [63:0] exp_q[$];
        logic [63:0] exp_fetch, req_addr, dummy;
        bit          pending;
        int          lat, got, cyc;
        exp_fetch = RPC; req_addr = 64'd0; pending = 1'b0; lat = 0; got = 0; cyc = 0;
        do_reset();
        while (got < 100 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            icache_data_valid = 1'b0;
            n_vec++; if (inst_valid !== (exp_q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, inst_valid, exp_q.size() != 0); end
            if (inst_valid && exp_q.size() != 0) begin
                n_vec++; if (inst_pc !== exp_q[0] || inst !== hash32(exp_q[0])) begin n_bad++; $display("FAIL rnd_head cyc %0d got %h/%h want %h/%h", cyc, inst_pc, inst, exp_q[0], hash32(exp_q[0])); end
            end
            if (pending) begin
                n_vec++; if (icache_addr_valid !== 1'b1 || icache_addr !== req_addr) begin n_bad++; $display("FAIL rnd_hold cyc %0d got %h/%0b want %h/1", cyc, icache_addr, icache_addr_valid, req_addr); end
            end else if (icache_addr_valid) begin
                n_vec++; if (icache_addr !== exp_fetch) begin n_bad++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, icache_addr, exp_fetch); end
                n_vec++; if (exp_q.size() >= DEPTH) begin n_bad++; $display("FAIL rnd_reserve cyc %0d occupancy %0d want below %0d", cyc, exp_q.size(), DEPTH); end
                pending = 1'b1; req_addr = icache_addr; lat = $urandom_range(0, 3);
            end
            inst_ready = ($urandom_range(0, 1) == 1);
            if (inst_valid && inst_ready && exp_q.size() != 0) begin
                dummy = exp_q.pop_front();
                got++;
            end
            if (pending) begin
                if (lat == 0) begin
                    icache_data = dword_at(req_addr); icache_data_valid = 1'b1;
                    exp_q.push_back(req_addr);
                    exp_fetch = exp_fetch + 64'd4;
                    pending = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
        @(negedge clk);
        icache_data_valid = 1'b0; inst_ready = 1'b0;
        n_vec++; if (got < 100) begin n_bad++; $display("FAIL rnd_timeout got %0d instructions want 100", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_pc_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
